// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: 15-entry register file, status machine and retired counter.
// Optional macro WB_BYPASS_EN forwards same-cycle commit data onto the read ports.
module writeback_regfile #(
  parameter int                  DATA_W   = 64,
  parameter logic [DATA_W-1:0]   SP_RESET = DATA_W'(1016),
  parameter int                  CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              mem_error,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [2:0]        stat,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  typedef enum logic [2:0] {
    ST_AOK = 3'd1,
    ST_HLT = 3'd2,
    ST_ADR = 3'd3,
    ST_INS = 3'd4
  } stat_e;

  stat_e             state_q, state_d;
  logic [DATA_W-1:0] rf_q [15];
  logic [DATA_W-1:0] rf_d [15];
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic [3:0] dst_e;
  logic [3:0] dst_m;
  logic       commit;
  logic       count_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    dst_e = REG_NONE;
    dst_m = REG_NONE;
    unique case (icode)
      I_CMOV:                       dst_e = cnd ? rB : REG_NONE;
      I_IRMOV, I_OPQ:               dst_e = rB;
      I_CALL, I_RET, I_PUSH, I_POP: dst_e = REG_RSP;
      default:                      dst_e = REG_NONE;
    endcase
    if (icode == I_MRMOV || icode == I_POP) dst_m = rA;
  end

  // Halt passes the commit gate but has no destinations and is not counted.
  assign commit   = wb_valid && (state_q == ST_AOK) && !mem_error && (icode <= I_POP);
  assign count_en = commit && (icode != I_HALT);

  always_comb begin
    state_d = state_q;
    if (wb_valid && state_q == ST_AOK) begin
      if (mem_error)            state_d = ST_ADR;
      else if (icode > I_POP)   state_d = ST_INS;
      else if (icode == I_HALT) state_d = ST_HLT;
    end
  end

  // Writing valM last lets it win when both destinations coincide (popq %rsp).
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      rf_d[i] = rf_q[i];
      if (commit && dst_e == 4'(i)) rf_d[i] = valE;
      if (commit && dst_m == 4'(i)) rf_d[i] = valM;
    end
    retired_d = count_en ? sat_inc(retired_q) : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_AOK;
      retired_q <= '0;
      for (int i = 0; i < 15; i++) begin
        rf_q[i] <= (4'(i) == REG_RSP) ? SP_RESET : '0;
      end
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      for (int i = 0; i < 15; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  always_comb begin
    valA = '0;
    valB = '0;
    for (int i = 0; i < 15; i++) begin
      if (srcA == 4'(i)) valA = rf_q[i];
      if (srcB == 4'(i)) valB = rf_q[i];
    end
`ifdef WB_BYPASS_EN
    if (commit) begin
      if (dst_e != REG_NONE && srcA == dst_e) valA = valE;
      if (dst_m != REG_NONE && srcA == dst_m) valA = valM;
      if (dst_e != REG_NONE && srcB == dst_e) valB = valE;
      if (dst_m != REG_NONE && srcB == dst_m) valB = valM;
    end
`endif
  end

  assign stat    = state_q;
  assign halted  = (state_q != ST_AOK);
  assign retired = retired_q;

endmodule
